// File: rtl/trolley_system_nios2_gen2_0_cpu_debug_mon_access_pkg.sv
// Shared definitions for the debug monitor access block: FSM states,
// default widths and the bit positions of the fields packed into jdo.
package trolley_system_nios2_gen2_0_cpu_debug_mon_access_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int JDO_W      = 38;

  // jdo field positions
  localparam int JDO_ADDR_LSB    = 10;  // address field jdo[17:10]
  localparam int JDO_RD_BIT      = 34;  // read request on ocimem_a
  localparam int JDO_AUTOINC_BIT = 35;  // auto-increment on ocimem_a
  localparam int JDO_WDATA_LSB   = 3;   // write data jdo[34:3]

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RD_ISSUE   = 2'd1,
    ST_RD_CAPTURE = 2'd2,
    ST_WR_ISSUE   = 2'd3
  } mon_state_e;

  // True when two or more of the three JTAG strobes are high together.
  function automatic logic multi_hot3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/trolley_system_nios2_gen2_0_cpu_debug_mon_access_if.sv
// CPU-side slave bus of the debug monitor RAM.
interface trolley_system_nios2_gen2_0_cpu_debug_mon_access_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid, avs_waitrequest
  );
endinterface

// File: rtl/trolley_system_nios2_gen2_0_cpu_debug_mon_ram.sv
// Single-port synchronous RAM, read-before-write, contents never reset.
module trolley_system_nios2_gen2_0_cpu_debug_mon_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write when enabled; the registered read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/trolley_system_nios2_gen2_0_cpu_debug_mon_access.sv
// JTAG debug monitor access: a small FSM turns JTAG strobes into RAM
// reads/writes; the CPU slave port shares the RAM and is stalled while
// the JTAG side owns the port.
module trolley_system_nios2_gen2_0_cpu_debug_mon_access
  import trolley_system_nios2_gen2_0_cpu_debug_mon_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [JDO_W-1:0]     jdo,
  input  logic                 take_action_ocimem_a,
  input  logic                 take_no_action_ocimem_a,
  input  logic                 take_action_ocimem_b,
  input  logic                 debugack,
  output logic [DATA_W-1:0]    MonDReg,
  output logic                 monitor_ready,
  output logic                 monitor_error,
  trolley_system_nios2_gen2_0_cpu_debug_mon_access_if.slave avs
);

  mon_state_e        state, state_next;
  logic [ADDR_W-1:0] addr;
  logic              autoinc;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mon_dreg;
  logic              mon_err;
  logic              rdv;

  logic [2:0]        strobes;
  logic              any_strobe, in_idle, jtag_port, cpu_req, cpu_grant;
  logic              load_addr, load_wdata, bump_addr, capture, err_set, err_clr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  logic              unused_jdo_bits;

  assign strobes    = {take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a};
  assign any_strobe = |strobes;
  assign in_idle    = (state == ST_IDLE);
  assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_AUTOINC_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

  // Next-state and datapath control; strobes are only acted on in IDLE.
  always_comb begin
    state_next = state;
    load_addr  = 1'b0;
    load_wdata = 1'b0;
    bump_addr  = 1'b0;
    capture    = 1'b0;
    err_clr    = 1'b0;
    err_set    = any_strobe & (~in_idle | multi_hot3(strobes) | ~debugack);
    case (state)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          load_addr  = 1'b1;
          err_clr    = 1'b1;
          state_next = jdo[JDO_RD_BIT] ? ST_RD_ISSUE : ST_IDLE;
        end else if (take_action_ocimem_b) begin
          load_wdata = 1'b1;
          state_next = ST_WR_ISSUE;
        end else if (take_no_action_ocimem_a) begin
          state_next = ST_RD_ISSUE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RD_ISSUE: state_next = ST_RD_CAPTURE;
      ST_RD_CAPTURE: begin
        capture    = 1'b1;
        bump_addr  = autoinc;
        state_next = ST_IDLE;
      end
      ST_WR_ISSUE: begin
        bump_addr  = autoinc;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // RAM port mux: JTAG owns the port in the issue states, CPU otherwise.
  always_comb begin
    jtag_port           = (state == ST_RD_ISSUE) | (state == ST_WR_ISSUE);
    cpu_req             = avs.avs_read | avs.avs_write;
    avs.avs_waitrequest = jtag_port & cpu_req;
    cpu_grant           = cpu_req & ~jtag_port;
    if (jtag_port) begin
      ram_addr  = addr;
      ram_we    = (state == ST_WR_ISSUE);
      ram_wdata = wdata;
    end else begin
      ram_addr  = avs.avs_address;
      ram_we    = avs.avs_write;
      ram_wdata = avs.avs_writedata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Address, mode, write-data, MonDReg, sticky error and CPU read-valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      autoinc  <= 1'b0;
      wdata    <= '0;
      mon_dreg <= '0;
      mon_err  <= 1'b0;
      rdv      <= 1'b0;
    end else begin
      if (load_addr) begin
        addr    <= jdo[JDO_ADDR_LSB +: ADDR_W];
        autoinc <= jdo[JDO_AUTOINC_BIT];
      end else if (bump_addr) begin
        addr <= addr + ADDR_W'(1);
      end
      if (load_wdata) begin
        wdata <= jdo[JDO_WDATA_LSB +: DATA_W];
      end
      if (capture) begin
        mon_dreg <= ram_q;
      end
      mon_err <= err_clr ? err_set : (mon_err | err_set);
      rdv     <= cpu_grant & avs.avs_read;
    end
  end

  trolley_system_nios2_gen2_0_cpu_debug_mon_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .wdata(ram_wdata),
    .q    (ram_q)
  );

  assign MonDReg               = mon_dreg;
  assign monitor_error         = mon_err;
  assign monitor_ready         = in_idle & ~any_strobe;
  assign avs.avs_readdatavalid = rdv;
  assign avs.avs_readdata      = rdv ? ram_q : '0;

endmodule

// File: tb/tb_trolley_system_nios2_gen2_0_cpu_debug_mon_access.sv
// Bench for the debug monitor access block: a directed vector table, a few
// multi-cycle corner sequences and a randomized phase against a
// transaction-level model (RAM array + address/mode/error registers).
module tb_trolley_system_nios2_gen2_0_cpu_debug_mon_access;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        ta, tn, tbw, debugack;
  logic [31:0] mon;
  logic        ready, err;

  always #5 clk = ~clk;

  trolley_system_nios2_gen2_0_cpu_debug_mon_access_if #(.ADDR_W(8), .DATA_W(32)) avs ();

  trolley_system_nios2_gen2_0_cpu_debug_mon_access #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta), .take_no_action_ocimem_a(tn),
    .take_action_ocimem_b(tbw), .debugack(debugack),
    .MonDReg(mon), .monitor_ready(ready), .monitor_error(err),
    .avs(avs)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_mem [0:255];
  logic [7:0]  m_addr;
  logic        m_auto, m_err;
  logic [31:0] m_mon;

  typedef struct {
    logic [1:0]  op;   // 0 = ocimem_a, 1 = ocimem_b, 2 = no_action read
    logic [7:0]  ad;
    logic        rd;
    logic        ai;
    logic [31:0] data;
    logic        dbg;
    logic [31:0] exp_mon;
    logic        exp_err;
  } vec_t;

  vec_t vt [16];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] ad, input logic rd, input logic ai);
    logic [37:0] r;
    r = 38'd0;
    r[17:10] = ad;
    r[34] = rd;
    r[35] = ai;
    return r;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] r;
    r = 38'd0;
    r[34:3] = d;
    return r;
  endfunction

  // model: transaction-level effect of each JTAG operation
  task automatic m_op_a(input logic [7:0] ad, input logic rd, input logic ai, input logic dbg);
    m_addr = ad;
    m_auto = ai;
    m_err  = !dbg;
    if (rd) begin
      m_mon = m_mem[m_addr];
      if (m_auto) m_addr = m_addr + 8'd1;
    end
  endtask

  task automatic m_op_b(input logic [31:0] d, input logic dbg);
    m_mem[m_addr] = d;
    if (m_auto) m_addr = m_addr + 8'd1;
    m_err = m_err | !dbg;
  endtask

  task automatic m_op_n(input logic dbg);
    m_mon = m_mem[m_addr];
    if (m_auto) m_addr = m_addr + 8'd1;
    m_err = m_err | !dbg;
  endtask

  task automatic pulse(input logic a, input logic b, input logic n, input logic [37:0] j, input logic dbg);
    @(posedge clk); #1;
    ta = a; tbw = b; tn = n; jdo = j; debugack = dbg;
    @(posedge clk); #1;
    ta = 1'b0; tbw = 1'b0; tn = 1'b0; jdo = 38'd0; debugack = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready) break;
    end
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL %s ready_timeout actual=0 expected=1", name);
    end
  endtask

  task automatic jtag_op(input logic [1:0] op, input logic [7:0] ad, input logic rd,
                         input logic ai, input logic [31:0] d, input logic dbg);
    case (op)
      2'd0: begin pulse(1'b1, 1'b0, 1'b0, jdo_a(ad, rd, ai), dbg); m_op_a(ad, rd, ai, dbg); end
      2'd1: begin pulse(1'b0, 1'b1, 1'b0, jdo_b(d), dbg);          m_op_b(d, dbg); end
      default: begin pulse(1'b0, 1'b0, 1'b1, 38'd0, dbg);          m_op_n(dbg); end
    endcase
    wait_ready("jtag_op");
  endtask

  task automatic cpu_write(input logic [7:0] ad, input logic [31:0] d);
    @(posedge clk); #1;
    avs.avs_write = 1'b1; avs.avs_address = ad; avs.avs_writedata = d;
    @(posedge clk); #1;
    avs.avs_write = 1'b0;
    m_mem[ad] = d;
  endtask

  task automatic cpu_read_check(input string name, input logic [7:0] ad);
    @(posedge clk); #1;
    avs.avs_read = 1'b1; avs.avs_address = ad;
    @(posedge clk); #1;
    avs.avs_read = 1'b0;
    @(negedge clk);
    check32({name, "_rdv"}, {31'd0, avs.avs_readdatavalid}, 32'd1);
    check32({name, "_data"}, avs.avs_readdata, m_mem[ad]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rseq;
    logic [1:0] op;

    reset = 1'b1; jdo = 38'd0; ta = 1'b0; tn = 1'b0; tbw = 1'b0; debugack = 1'b1;
    avs.avs_read = 1'b0; avs.avs_write = 1'b0; avs.avs_address = 8'd0; avs.avs_writedata = 32'd0;
    m_addr = 8'd0; m_auto = 1'b0; m_err = 1'b0; m_mon = 32'd0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_mon", mon, 32'd0);
    check32("rst_ready", {31'd0, ready}, 32'd1);
    check32("rst_err", {31'd0, err}, 32'd0);
    check32("rst_rdv", {31'd0, avs.avs_readdatavalid}, 32'd0);
    check32("rst_rdata", avs.avs_readdata, 32'd0);
    check32("rst_wait", {31'd0, avs.avs_waitrequest}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // give every RAM word a known value
    for (int i = 0; i < 256; i++) cpu_write(i[7:0], $urandom);

    // directed table: writes, reads, auto-increment, wrap, debugack errors
    vt[0]  = '{2'd0, 8'h10, 1'b0, 1'b1, 32'h0,        1'b1, 32'h0,        1'b0};
    vt[1]  = '{2'd1, 8'h00, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0};
    vt[2]  = '{2'd1, 8'h00, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0};
    vt[3]  = '{2'd0, 8'h10, 1'b1, 1'b1, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vt[4]  = '{2'd2, 8'h00, 1'b0, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vt[5]  = '{2'd1, 8'h00, 1'b0, 1'b0, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0};
    vt[6]  = '{2'd0, 8'h12, 1'b1, 1'b0, 32'h0,        1'b1, 32'h12345678, 1'b0};
    vt[7]  = '{2'd2, 8'h00, 1'b0, 1'b0, 32'h0,        1'b1, 32'h12345678, 1'b0};
    vt[8]  = '{2'd0, 8'hFF, 1'b0, 1'b1, 32'h0,        1'b1, 32'h12345678, 1'b0};
    vt[9]  = '{2'd1, 8'h00, 1'b0, 1'b0, 32'hCAFEF00D, 1'b1, 32'h12345678, 1'b0};
    vt[10] = '{2'd1, 8'h00, 1'b0, 1'b0, 32'h0BADF00D, 1'b1, 32'h12345678, 1'b0};
    vt[11] = '{2'd0, 8'hFF, 1'b1, 1'b1, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
    vt[12] = '{2'd2, 8'h00, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0BADF00D, 1'b0};
    vt[13] = '{2'd0, 8'h10, 1'b1, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
    vt[14] = '{2'd2, 8'h00, 1'b0, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1};
    vt[15] = '{2'd0, 8'h11, 1'b1, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    for (int i = 0; i < 16; i++) begin
      jtag_op(vt[i].op, vt[i].ad, vt[i].rd, vt[i].ai, vt[i].data, vt[i].dbg);
      check32($sformatf("vec%0d_mon", i), mon, vt[i].exp_mon);
      check32($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vt[i].exp_err});
    end

    // read latency: monitor_ready low for strobe, RD_ISSUE, RD_CAPTURE
    @(posedge clk); #1;
    ta = 1'b1; jdo = jdo_a(8'h10, 1'b1, 1'b1);
    @(negedge clk); rseq[3] = ready;
    @(posedge clk); #1; ta = 1'b0; jdo = 38'd0;
    @(negedge clk); rseq[2] = ready;
    @(negedge clk); rseq[1] = ready;
    @(negedge clk); rseq[0] = ready;
    m_op_a(8'h10, 1'b1, 1'b1, 1'b1);
    check32("lat_ready_seq", {28'd0, rseq}, 32'h1);
    check32("lat_mon", mon, 32'hDEADBEEF);

    // CPU read stalled by JTAG write, granted next cycle
    @(posedge clk); #1;
    tbw = 1'b1; jdo = jdo_b(32'h55AA33CC);
    @(posedge clk); #1;
    tbw = 1'b0; jdo = 38'd0;
    avs.avs_read = 1'b1; avs.avs_address = 8'h20;
    @(negedge clk);
    check32("stall_wait_hi", {31'd0, avs.avs_waitrequest}, 32'd1);
    check32("stall_rdv_lo", {31'd0, avs.avs_readdatavalid}, 32'd0);
    @(negedge clk);
    check32("stall_wait_lo", {31'd0, avs.avs_waitrequest}, 32'd0);
    @(posedge clk); #1;
    avs.avs_read = 1'b0;
    @(negedge clk);
    check32("stall_rdv", {31'd0, avs.avs_readdatavalid}, 32'd1);
    check32("stall_rdata", avs.avs_readdata, m_mem[8'h20]);
    @(negedge clk);
    check32("stall_rdv_once", {31'd0, avs.avs_readdatavalid}, 32'd0);
    m_op_b(32'h55AA33CC, 1'b1);
    cpu_read_check("stall_wr_landed", 8'h11);

    // strobe during RD_CAPTURE is ignored and flags an error
    @(posedge clk); #1;
    ta = 1'b1; jdo = jdo_a(8'h30, 1'b1, 1'b0);
    @(posedge clk); #1; ta = 1'b0; jdo = 38'd0;
    @(posedge clk); #1; tbw = 1'b1; jdo = jdo_b(32'hFFFF0000);
    @(posedge clk); #1; tbw = 1'b0; jdo = 38'd0;
    m_op_a(8'h30, 1'b1, 1'b0, 1'b1);
    m_err = 1'b1;
    @(negedge clk);
    check32("busy_err", {31'd0, err}, 32'd1);
    check32("busy_mon", mon, m_mon);
    cpu_read_check("busy_no_write", 8'h30);
    jtag_op(2'd0, 8'h30, 1'b0, 1'b0, 32'h0, 1'b1);
    check32("busy_err_clr", {31'd0, err}, 32'd0);

    // coincident ocimem_a + ocimem_b: ocimem_a wins, error set
    pulse(1'b1, 1'b1, 1'b0, jdo_a(8'h40, 1'b1, 1'b0), 1'b1);
    m_op_a(8'h40, 1'b1, 1'b0, 1'b1);
    m_err = 1'b1;
    wait_ready("coinc");
    check32("coinc_mon", mon, m_mon);
    check32("coinc_err", {31'd0, err}, 32'd1);

    // reset during RD_ISSUE aborts the read
    @(posedge clk); #1;
    ta = 1'b1; jdo = jdo_a(8'h20, 1'b1, 1'b1);
    @(posedge clk); #1;
    ta = 1'b0; jdo = 38'd0; reset = 1'b1;
    @(negedge clk);
    check32("mid_rst_mon", mon, 32'd0);
    check32("mid_rst_ready", {31'd0, ready}, 32'd1);
    check32("mid_rst_err", {31'd0, err}, 32'd0);
    check32("mid_rst_rdv", {31'd0, avs.avs_readdatavalid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_addr = 8'd0; m_auto = 1'b0; m_mon = 32'd0; m_err = 1'b0;
    jtag_op(2'd2, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    check32("post_rst_read0", mon, m_mon);

    // randomized mix against the model
    for (int i = 0; i < 120; i++) begin
      op = 2'($urandom_range(0, 4));
      case ($urandom_range(0, 4))
        0, 1, 2: begin
          jtag_op(2'($urandom_range(0, 2)), 8'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, ($urandom_range(0, 7) != 0));
          check32($sformatf("rnd%0d_mon", i), mon, m_mon);
          check32($sformatf("rnd%0d_err", i), {31'd0, err}, {31'd0, m_err});
        end
        3: cpu_write(8'($urandom), $urandom);
        default: cpu_read_check($sformatf("rnd%0d_cpu", i), 8'($urandom));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
